// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between two masters (master 0: CPU-side bus
// adapter, master 1: program loader / debug DMA). Each request is a single
// read or write. Arbitration is round-robin. The block drives the memory's
// active-low read/write strobes, address and write data. Read data is
// registered and returned to the winning master with a one-cycle ack pulse.
//
// Optional feature (compile-time macro ARB_LOCK_EN):
//   Adds lock0/lock1 inputs. An owner that holds lock and req at the end of
//   its DONE cycle keeps the port and starts its next access immediately,
//   with no IDLE cycle in between.
//
// Ports
//   clk, rst            clock (posedge), asynchronous active-high reset
//   req0/req1           request, held with we/addr/wdata stable until ack
//   we0/we1             1 = write, 0 = read
//   addr0/addr1         transaction address
//   wdata0/wdata1       write data
//   lock0/lock1         keep ownership for the next request (ARB_LOCK_EN)
//   gnt0/gnt1           master owns the port (ACCESS and DONE)
//   ack0/ack1           one-cycle completion pulse, rdata valid with it
//   rdata               registered read data, held until the next read
//   mem_r_n/mem_w_n     memory read/write strobes, active low
//   mem_addr/mem_wdata  memory address / write data
//   mem_rdata           memory read data
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W        = 16,
   parameter int DATA_W        = 16,
   parameter int ACCESS_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
`ifdef ARB_LOCK_EN
   input  logic              lock0,
   input  logic              lock1,
`endif
   output logic              gnt0,
   output logic              gnt1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_r_n,
   output logic              mem_w_n,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // The counter holds the number of strobe cycles still to go after the
   // current one, so an access of N cycles loads N-1.
   localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

   // Round-robin pick: a lone requester wins; on a tie the master that did
   // not win last time gets the port.
   function automatic logic pick_winner(input logic r0, input logic r1, input logic lst);
      logic w;
      if (r0 && r1) begin
         w = ~lst;
      end else if (r1) begin
         w = 1'b1;
      end else begin
         w = 1'b0;
      end
      return w;
   endfunction

   // registers
   state_t              state_r;
   logic                last_r;
   logic [3:0]          cnt_r;
   logic [1:0]          gnt_r;
   logic [1:0]          ack_r;
   logic [DATA_W-1:0]   rdata_r;
   logic                mem_r_n_r;
   logic                mem_w_n_r;
   logic [ADDR_W-1:0]   mem_addr_r;
   logic [DATA_W-1:0]   mem_wdata_r;

   // next-state values
   state_t              state_s;
   logic                last_s;
   logic [3:0]          cnt_s;
   logic [1:0]          gnt_s;
   logic [1:0]          ack_s;
   logic [DATA_W-1:0]   rdata_s;
   logic                mem_r_n_s;
   logic                mem_w_n_s;
   logic [ADDR_W-1:0]   mem_addr_s;
   logic [DATA_W-1:0]   mem_wdata_s;

   // selected master and its transaction fields
   logic                sel_s;
   logic                sel_we_s;
   logic [ADDR_W-1:0]   sel_addr_s;
   logic [DATA_W-1:0]   sel_wdata_s;
   logic                lock_go_s;
   logic                start_s;

`ifdef ARB_LOCK_EN
   // The current owner (last_r) keeps the port when it asks again under lock.
   assign lock_go_s = (state_r == ST_DONE) &&
                      (last_r ? (lock1 && req1) : (lock0 && req0));
`else
   assign lock_go_s = 1'b0;
`endif

   // Choose which master's request is presented: arbitrate in IDLE, otherwise the owner.
   always_comb begin
      sel_s = last_r;
      if (state_r == ST_IDLE) begin
         sel_s = pick_winner(req0, req1, last_r);
      end else begin
         sel_s = last_r;
      end
      sel_we_s    = sel_s ? we1    : we0;
      sel_addr_s  = sel_s ? addr1  : addr0;
      sel_wdata_s = sel_s ? wdata1 : wdata0;
      start_s     = ((state_r == ST_IDLE) && (req0 || req1)) || lock_go_s;
   end

   // Next-state and next-output logic for the arbiter FSM.
   always_comb begin
      state_s     = state_r;
      last_s      = last_r;
      cnt_s       = cnt_r;
      gnt_s       = gnt_r;
      ack_s       = 2'b00;
      rdata_s     = rdata_r;
      mem_r_n_s   = mem_r_n_r;
      mem_w_n_s   = mem_w_n_r;
      mem_addr_s  = mem_addr_r;
      mem_wdata_s = mem_wdata_r;

      if (start_s) begin
         // launch an access for the selected master
         state_s     = ST_ACCESS;
         last_s      = sel_s;
         cnt_s       = CNT_LOAD;
         gnt_s       = sel_s ? 2'b10 : 2'b01;
         mem_r_n_s   = sel_we_s;
         mem_w_n_s   = ~sel_we_s;
         mem_addr_s  = sel_addr_s;
         mem_wdata_s = sel_wdata_s;
      end else begin
         case (state_r)
            ST_IDLE: begin
               gnt_s = 2'b00;
            end
            ST_ACCESS: begin
               if (cnt_r != 4'd0) begin
                  cnt_s = cnt_r - 4'd1;
               end else begin
                  // a low read strobe marks this access as a read
                  if (!mem_r_n_r) begin
                     rdata_s = mem_rdata;
                  end else begin
                     rdata_s = rdata_r;
                  end
                  mem_r_n_s = 1'b1;
                  mem_w_n_s = 1'b1;
                  ack_s     = last_r ? 2'b10 : 2'b01;
                  state_s   = ST_DONE;
               end
            end
            ST_DONE: begin
               gnt_s   = 2'b00;
               state_s = ST_IDLE;
            end
            default: begin
               gnt_s     = 2'b00;
               mem_r_n_s = 1'b1;
               mem_w_n_s = 1'b1;
               state_s   = ST_IDLE;
            end
         endcase
      end
   end

   // State and output registers; reset parks the strobes high and favours master 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         last_r      <= 1'b1;
         cnt_r       <= 4'd0;
         gnt_r       <= 2'b00;
         ack_r       <= 2'b00;
         rdata_r     <= '0;
         mem_r_n_r   <= 1'b1;
         mem_w_n_r   <= 1'b1;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
      end else begin
         state_r     <= state_s;
         last_r      <= last_s;
         cnt_r       <= cnt_s;
         gnt_r       <= gnt_s;
         ack_r       <= ack_s;
         rdata_r     <= rdata_s;
         mem_r_n_r   <= mem_r_n_s;
         mem_w_n_r   <= mem_w_n_s;
         mem_addr_r  <= mem_addr_s;
         mem_wdata_r <= mem_wdata_s;
      end
   end

   assign gnt0      = gnt_r[0];
   assign gnt1      = gnt_r[1];
   assign ack0      = ack_r[0];
   assign ack1      = ack_r[1];
   assign rdata     = rdata_r;
   assign mem_r_n   = mem_r_n_r;
   assign mem_w_n   = mem_w_n_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed and randomized bench for mem_port_arbiter (ACCESS_CYCLES = 3).
// The bench plays both masters and the memory. Expected behaviour comes
// from a transaction-level model: the round-robin rule decides the winner,
// each access holds its strobe for ACCESS_CYCLES cycles, then acks with
// data from the bench memory array, then one IDLE cycle follows.
// Build with ARB_LOCK_EN defined to also exercise the locked sequence.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int AC = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1, we0, we1;
   logic [15:0] addr0, addr1, wdata0, wdata1;
   logic        lock0, lock1;
   logic        gnt0, gnt1, ack0, ack1;
   logic [15:0] rdata;
   logic        mem_r_n, mem_w_n;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;

   logic [15:0] mem_arr [0:255];

   // model state
   logic        m_last;
   logic [15:0] m_rdata, m_addr, m_wdata;
   int          n_asserts = 0;
   int          n_fails   = 0;
   int          w;

   always #5 clk = ~clk;

   assign mem_rdata = mem_arr[mem_addr[7:0]];

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .ACCESS_CYCLES(AC)) u_dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
`ifdef ARB_LOCK_EN
      .lock0(lock0), .lock1(lock1),
`endif
      .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
      .rdata(rdata), .mem_r_n(mem_r_n), .mem_w_n(mem_w_n),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_m(input int m, input logic r, input logic wr,
                        input logic [15:0] a, input logic [15:0] d);
      if (m == 0) begin
         req0 = r; we0 = wr; addr0 = a; wdata0 = d;
      end else begin
         req1 = r; we1 = wr; addr1 = a; wdata1 = d;
      end
   endtask

   task automatic rand_req(input int m);
      logic [15:0] a;
      a = {8'($urandom), 8'($urandom_range(0, 15))};
      set_m(m, 1'b1, 1'($urandom_range(0, 1)), a, 16'($urandom));
   endtask

   // One transaction, entered at a negedge with inputs set; returns at the
   // negedge of the ack cycle. force_w >= 0 means the owner continues (lock).
   task automatic run_txn(input int force_w, input bit drop_mid, output int win);
      logic        wwe;
      logic [15:0] wa, wd;
      if (force_w >= 0)        win = force_w;
      else if (req0 && req1)   win = m_last ? 0 : 1;
      else if (req1)           win = 1;
      else                     win = 0;
      wwe = (win == 1) ? we1 : we0;
      wa  = (win == 1) ? addr1 : addr0;
      wd  = (win == 1) ? wdata1 : wdata0;
      for (int c = 0; c < AC; c++) begin
         @(posedge clk); @(negedge clk);
         if (c == 0 && drop_mid) set_m(win, 1'b0, wwe, wa, wd);
         chk("gnt_owner", (win == 1) ? gnt1 : gnt0, 1);
         chk("gnt_other", (win == 1) ? gnt0 : gnt1, 0);
         chk("mem_r_n_acc", mem_r_n, wwe);
         chk("mem_w_n_acc", mem_w_n, !wwe);
         chk("mem_addr_acc", mem_addr, wa);
         chk("mem_wdata_acc", mem_wdata, wd);
         chk("ack_early", {ack1, ack0}, 0);
      end
      @(posedge clk); @(negedge clk);
      if (!wwe) m_rdata = mem_arr[wa[7:0]];
      else      mem_arr[wa[7:0]] = wd;
      m_last  = (win == 1);
      m_addr  = wa;
      m_wdata = wd;
      chk("mem_r_n_done", mem_r_n, 1);
      chk("mem_w_n_done", mem_w_n, 1);
      chk("ack_owner", (win == 1) ? ack1 : ack0, 1);
      chk("ack_other", (win == 1) ? ack0 : ack1, 0);
      chk("gnt_done", (win == 1) ? gnt1 : gnt0, 1);
      chk("rdata", rdata, m_rdata);
      chk("mem_addr_done", mem_addr, wa);
   endtask

   // Advance one cycle and expect an idle port with held address/data.
   task automatic idle_check();
      @(posedge clk); @(negedge clk);
      chk("gnt_idle", {gnt1, gnt0}, 0);
      chk("ack_idle", {ack1, ack0}, 0);
      chk("strobes_idle", {mem_r_n, mem_w_n}, 2'b11);
      chk("mem_addr_hold", mem_addr, m_addr);
      chk("mem_wdata_hold", mem_wdata, m_wdata);
      chk("rdata_hold", rdata, m_rdata);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem_arr[i] = 16'($urandom);
      rst = 1'b1; lock0 = 1'b0; lock1 = 1'b0;
      set_m(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      set_m(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      m_last = 1'b1; m_rdata = 16'h0000; m_addr = 16'h0000; m_wdata = 16'h0000;

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_gnt", {gnt1, gnt0}, 0);
      chk("rst_ack", {ack1, ack0}, 0);
      chk("rst_strobes", {mem_r_n, mem_w_n}, 2'b11);
      chk("rst_addr", mem_addr, 16'h0000);
      chk("rst_wdata", mem_wdata, 16'h0000);
      chk("rst_rdata", rdata, 16'h0000);
      rst = 1'b0;

      // master 0 read of 0x0010
      mem_arr[8'h10] = 16'hBEEF;
      set_m(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
      run_txn(-1, 1'b0, w);
      set_m(0, 1'b0, 1'b0, 16'h0010, 16'h0000);
      idle_check();

      // both masters held: alternating grants over 4 transactions
      rand_req(0); rand_req(1);
      for (int i = 0; i < 4; i++) begin
         run_txn(-1, 1'b0, w);
         rand_req(w);
         idle_check();
      end
      set_m(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      set_m(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      idle_check();

      // master 1 write 0x1234 to 0x00FE
      set_m(1, 1'b1, 1'b1, 16'h00FE, 16'h1234);
      run_txn(-1, 1'b0, w);
      set_m(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      idle_check();

      // rdata survives a write: write 0xAAAA, read it back, then write again
      set_m(0, 1'b1, 1'b1, 16'h0020, 16'hAAAA);
      run_txn(-1, 1'b0, w);
      set_m(0, 1'b1, 1'b0, 16'h0020, 16'h0000);
      idle_check();
      run_txn(-1, 1'b0, w);
      chk("rdata_aaaa", rdata, 16'hAAAA);
      set_m(0, 1'b1, 1'b1, 16'h0021, 16'h5555);
      idle_check();
      run_txn(-1, 1'b0, w);
      chk("rdata_after_wr", rdata, 16'hAAAA);
      set_m(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      idle_check();

      // request withdrawn mid-access still completes
      set_m(1, 1'b1, 1'b0, 16'h0033, 16'h0000);
      run_txn(-1, 1'b1, w);
      idle_check();

      // reset during a write access
      set_m(0, 1'b1, 1'b1, 16'h0044, 16'h7777);
      @(posedge clk); @(negedge clk);
      chk("pre_rst_w_n", mem_w_n, 0);
      rst = 1'b1;
      #1;
      chk("async_w_n", mem_w_n, 1);
      chk("async_gnt", {gnt1, gnt0}, 0);
      chk("async_ack", {ack1, ack0}, 0);
      #1;
      rst = 1'b0;
      m_last = 1'b1; m_rdata = 16'h0000; m_addr = 16'h0000; m_wdata = 16'h0000;
      rand_req(0); rand_req(1);
      run_txn(-1, 1'b0, w);
      chk("post_rst_winner", gnt0, 1);
      set_m(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      idle_check();
      run_txn(-1, 1'b0, w);
      set_m(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      idle_check();

`ifdef ARB_LOCK_EN
      // locked write then read by master 1 while master 0 waits
      set_m(0, 1'b1, 1'b0, 16'h0055, 16'h0000);
      set_m(1, 1'b1, 1'b1, 16'h0066, 16'hC0DE);
      lock1 = 1'b1;
      if (m_last) begin
         run_txn(-1, 1'b0, w);
         rand_req(0);
         idle_check();
      end
      run_txn(-1, 1'b0, w);
      set_m(1, 1'b1, 1'b0, 16'h0066, 16'h0000);
      run_txn(1, 1'b0, w);
      set_m(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      lock1 = 1'b0;
      idle_check();
      run_txn(-1, 1'b0, w);
      chk("lock_release_m0", gnt0, 1);
      set_m(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      idle_check();
`endif

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         if (!req0 && $urandom_range(0, 3) != 0) rand_req(0);
         if (!req1 && $urandom_range(0, 3) != 0) rand_req(1);
         if (!req0 && !req1) begin
            idle_check();
         end else begin
            run_txn(-1, 1'b0, w);
            if ($urandom_range(0, 1) == 1) rand_req(w);
            else set_m(w, 1'b0, 1'b0, 16'h0000, 16'h0000);
            idle_check();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
